// File: rtl/condlogic_pipe.sv
// rtl/condlogic_pipe.sv - ARM condition check, flag register and delayed write-enable pipeline
//
// Purpose:
//   Evaluates the ARM condition field against the architectural {N,Z,C,V}
//   flags, conditionally updates those flags from the ALU, and carries the
//   condition result through a DELAY-deep pipeline so the register, memory
//   and PC write enables are qualified in the stage where the write happens.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   Cond[3:0]         condition field of the current instruction
//   ALUFlags[3:0]     {N,Z,C,V} from the ALU this cycle
//   FlagW[1:0]        bit1 writes N,Z; bit0 writes C,V
//   PCS, NextPC       conditional / unconditional PC write requests
//   RegW, MemW        register-file and memory write requests
//   Stall, Flush      hold all state / discard in-flight condition results
//   PCWrite, RegWrite, MemWrite   qualified write enables
//   CondEx            undelayed condition result
//   Flags[3:0]        architectural {N,Z,C,V}
//   SaveFlags, RestoreFlags, ShadowFlags[3:0]  only with CONDLOGIC_SHADOW_EN
//
// Configuration:
//   CONDLOGIC_SHADOW_EN  adds a 4-bit shadow copy of the flags with
//                        save / restore / swap control.

module condlogic_pipe #(
  parameter int unsigned DELAY      = 1,
  parameter logic [3:0]  FLAG_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       NextPC,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       Stall,
  input  logic       Flush,
`ifdef CONDLOGIC_SHADOW_EN
  input  logic       SaveFlags,
  input  logic       RestoreFlags,
  output logic [3:0] ShadowFlags,
`endif
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags
);

  logic [3:0]       flags_q, flags_d;
  logic [DELAY-1:0] stage_q, stage_d;
  logic [DELAY:0]   shift_in;
  logic             n_flag, z_flag, c_flag, v_flag;
  logic             flag_wr_ok;
  logic             cond_ex_delayed;

  assign {n_flag, z_flag, c_flag, v_flag} = flags_q;

  // Condition evaluation always uses the registered flags, so an instruction
  // that writes flags sees the values from before its own write.
  always_comb begin
    CondEx = 1'b1;
    case (Cond)
      4'b0000: CondEx = z_flag;
      4'b0001: CondEx = ~z_flag;
      4'b0010: CondEx = c_flag;
      4'b0011: CondEx = ~c_flag;
      4'b0100: CondEx = n_flag;
      4'b0101: CondEx = ~n_flag;
      4'b0110: CondEx = v_flag;
      4'b0111: CondEx = ~v_flag;
      4'b1000: CondEx = c_flag & ~z_flag;
      4'b1001: CondEx = ~c_flag | z_flag;
      4'b1010: CondEx = (n_flag == v_flag);
      4'b1011: CondEx = (n_flag != v_flag);
      4'b1100: CondEx = ~z_flag & (n_flag == v_flag);
      4'b1101: CondEx = z_flag | (n_flag != v_flag);
      default: CondEx = 1'b1;
    endcase
  end

`ifdef CONDLOGIC_SHADOW_EN
  logic [3:0] shadow_q, shadow_d;

  // Save and restore act regardless of Stall/Flush; asserting both swaps,
  // since each side loads the other's pre-edge value.
  always_comb begin
    shadow_d = shadow_q;
    if (SaveFlags) shadow_d = flags_q;
  end

  always_ff @(posedge clk) begin
    if (reset) shadow_q <= FLAG_RESET;
    else       shadow_q <= shadow_d;
  end

  assign ShadowFlags = shadow_q;
`endif

  always_comb begin
    flag_wr_ok = CondEx & ~Stall & ~Flush;
    flags_d    = flags_q;
    if (FlagW[1] & flag_wr_ok) flags_d[3:2] = ALUFlags[3:2];
    if (FlagW[0] & flag_wr_ok) flags_d[1:0] = ALUFlags[1:0];
`ifdef CONDLOGIC_SHADOW_EN
    if (RestoreFlags) flags_d = shadow_q;
`endif
  end

  // Stage 0 takes the fresh CondEx, older values move toward stage DELAY-1.
  // The extra bit keeps the slice constant and legal for DELAY == 1.
  assign shift_in = {stage_q, CondEx};

  always_comb begin
    stage_d = stage_q;
    if (Flush)       stage_d = '0;
    else if (!Stall) stage_d = shift_in[DELAY-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= FLAG_RESET;
      stage_q <= '0;
    end else begin
      flags_q <= flags_d;
      stage_q <= stage_d;
    end
  end

  assign cond_ex_delayed = stage_q[DELAY-1];
  assign RegWrite        = RegW & cond_ex_delayed;
  assign MemWrite        = MemW & cond_ex_delayed;
  assign PCWrite         = (PCS & cond_ex_delayed) | NextPC;
  assign Flags           = flags_q;

endmodule

// File: doc/condlogic_pipe.md
CONDLOGIC_PIPE -- requirements
Module: condlogic_pipe

Interface
REQ-001 SHALL have parameter DELAY, default 1, meaning the number of register stages between CondEx and its use in the write enables; legal range 1..4.
REQ-002 SHALL have parameter FLAG_RESET, default 4'b0000, meaning the {N,Z,C,V} value loaded on reset.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Cond  input  4  ARM condition field of the current instruction.
REQ-006 SHALL have port ALUFlags  input  4  {N,Z,C,V} produced by the ALU this cycle.
REQ-007 SHALL have port FlagW  input  2  bit1 = write N,Z; bit0 = write C,V.
REQ-008 SHALL have ports PCS, NextPC, RegW and MemW  input  1 each  unconditional write requests from the main decoder/FSM.
REQ-009 SHALL have port Stall  input  1  hold all state except reset.
REQ-010 SHALL have port Flush  input  1  discard in-flight conditional results.
REQ-011 SHALL have ports PCWrite, RegWrite and MemWrite  output  1 each  qualified write enables.
REQ-012 SHALL have port CondEx  output  1  undelayed condition result.
REQ-013 SHALL have port Flags  output  4  current architectural {N,Z,C,V}.

Function
REQ-014 CondEx SHALL be combinational from Cond and registered Flags:
- EQ Z; NE ~Z; CS C; CC ~C; MI N; PL ~N; VS V; VC ~V
- HI C&~Z; LS ~C|Z; GE N==V; LT N!=V; GT ~Z&(N==V); LE Z|(N!=V)
- AL (1110) 1; 1111 1.
REQ-015 Flags[3:2] SHALL load ALUFlags[3:2] at the next edge iff FlagW[1] & CondEx & ~Stall & ~Flush.
REQ-016 Flags[1:0] SHALL load ALUFlags[1:0] at the next edge iff FlagW[0] & CondEx & ~Stall & ~Flush.
REQ-017 A DELAY-deep shift register SHALL capture CondEx into stage 0 and shift toward stage DELAY-1 on each edge with Stall=0; CondExDelayed is stage DELAY-1.
REQ-018 Stall=1 SHALL hold Flags and every pipeline stage unchanged.
REQ-019 Flush=1 SHALL clear every pipeline stage to 0 at the next edge and has priority over Stall.
REQ-020 Outputs SHALL be:
- RegWrite = RegW & CondExDelayed
- MemWrite = MemW & CondExDelayed
- PCWrite = (PCS & CondExDelayed) | NextPC
REQ-021 All outputs SHALL be combinational from the current inputs and state, with no extra register.
REQ-022 Latency SHALL be: a CondEx value sampled at edge k gates the write enables after edge k+DELAY-1, counting only edges with Stall=0.
REQ-023 A flag write and a condition evaluation in the same cycle SHALL see the pre-write Flags; there is no bypass.

Reset
REQ-024 reset=1 at an edge SHALL load Flags=FLAG_RESET and clear every pipeline stage, shadow register included when present.
REQ-025 Reset SHALL have priority over Stall, Flush, FlagW and restore.
REQ-026 While state is reset, RegWrite=0, MemWrite=0, PCWrite=NextPC, and CondEx follows REQ-014 for FLAG_RESET.
REQ-027 Reset asserted mid-pipeline SHALL discard all in-flight CondEx values, with no write enable from them afterward.

Configuration
REQ-028 Macro CONDLOGIC_SHADOW_EN defined SHALL add:
- inputs SaveFlags and RestoreFlags, 1 bit each
- output ShadowFlags, 4 bits, with a 4-bit shadow register.
REQ-029 With CONDLOGIC_SHADOW_EN defined, shadow register behaviour SHALL be:
- SaveFlags=1 copies Flags to the shadow at the next edge.
- RestoreFlags=1 loads the shadow into Flags, overriding REQ-015/016.
- Both asserted swaps Flags and the shadow.
- Save and restore ignore Stall and Flush.
REQ-030 Without CONDLOGIC_SHADOW_EN, those ports and the shadow register SHALL be absent and behaviour SHALL be per REQ-014..027 only.

Verification
REQ-031 DELAY=1: reset, then Cond=0000, RegW=1 -> CondEx=0, then RegWrite=0 next cycle. Then FlagW=11, Cond=1110, ALUFlags=0100 -> Flags=0100, and with Cond=0000 RegWrite=1 one edge later.
REQ-032 Cond=1010 (GE), Flags=1001 -> CondEx=1; Flags=1000 -> CondEx=0. Cond=1100 (GT), Flags=0101 -> CondEx=0.
REQ-033 DELAY=3: CondEx=1 for one cycle with MemW=1 held -> MemWrite=1 exactly two edges later, one cycle wide. Inserting one Stall cycle delays it by one cycle.
REQ-034 DELAY=2: CondEx=1, then Flush=1 together with Stall=1 on the following edge -> MemWrite and RegWrite never assert; NextPC=1 -> PCWrite=1 regardless.
REQ-035 FlagW=01, CondEx=0 (Cond=0001, Z=1) -> Flags unchanged. FlagW=01, Stall=1, Cond=1110 -> Flags unchanged.
REQ-036 CONDLOGIC_SHADOW_EN: Flags=0110, SaveFlags=1 -> ShadowFlags=0110. Then Flags set to 1001 and both Save and Restore asserted -> Flags=0110, ShadowFlags=1001. Reset -> both equal FLAG_RESET.
